// File: rtl/dcache_tag_ctrl.sv
// Lookup and miss controller for a 128-set direct-mapped dCache.
// Resolves hit/miss against the tag array and sequences writeback/refill.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | ready for a new LSU request
// S_LOOKUP  | tag array read data valid, resolve hit or miss
// S_WB_REQ  | present dirty-victim writeback request until accepted
// S_WB_WAIT | wait for writeback completion pulse
// S_RF_REQ  | present refill request until accepted
// S_RF_WAIT | wait for refill completion pulse
// S_UPDATE  | write the new tag entry
// S_RESP    | hold the lookup result until the LSU takes it
module dcache_tag_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int OFFSET_W   = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic                  i_req_wr,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic                  o_resp_hit,
    output logic                  o_tag_wen,
    output logic [6:0]            o_tag_addr,
    output logic [DATA_WIDTH-1:0] o_tag_din,
    input  logic [DATA_WIDTH-1:0] i_tag_dout,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic                  o_mem_wb,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic                  i_mem_done,
    output logic [31:0]           o_hit_cnt,
    output logic [31:0]           o_miss_cnt
);

    localparam int TAG_W = ADDR_W - 7 - OFFSET_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB_REQ,
        S_WB_WAIT,
        S_RF_REQ,
        S_RF_WAIT,
        S_UPDATE,
        S_RESP
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  req_addr;
    logic               req_wr;
    logic [TAG_W-1:0]   victim_tag;
    logic               resp_hit;
    logic [31:0]        hit_cnt;
    logic [31:0]        miss_cnt;

    logic [TAG_W-1:0]   req_tag;
    logic [6:0]         req_idx;
    logic               entry_valid;
    logic               entry_dirty;
    logic [TAG_W-1:0]   entry_tag;
    logic               lookup_hit;

    assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx     = req_addr[OFFSET_W+6:OFFSET_W];
    assign entry_valid = i_tag_dout[TAG_W+1];
    assign entry_dirty = i_tag_dout[TAG_W];
    assign entry_tag   = i_tag_dout[TAG_W-1:0];
    assign lookup_hit  = entry_valid && (entry_tag == req_tag);

    // Entry bits above valid and the request byte offset carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{i_tag_dout[DATA_WIDTH-1:TAG_W+2], req_addr[OFFSET_W-1:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_wr     <= 1'b0;
            victim_tag <= '0;
            resp_hit   <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        req_addr <= i_req_addr;
                        req_wr   <= i_req_wr;
                        state    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lookup_hit) begin
                        hit_cnt  <= hit_cnt + 32'd1;
                        resp_hit <= 1'b1;
                        state    <= S_RESP;
                    end else begin
                        miss_cnt   <= miss_cnt + 32'd1;
                        resp_hit   <= 1'b0;
                        victim_tag <= entry_tag;
                        state      <= (entry_valid && entry_dirty) ? S_WB_REQ : S_RF_REQ;
                    end
                end
                S_WB_REQ: begin
                    if (i_mem_ready) state <= S_WB_WAIT;
                end
                S_WB_WAIT: begin
                    if (i_mem_done) state <= S_RF_REQ;
                end
                S_RF_REQ: begin
                    if (i_mem_ready) state <= S_RF_WAIT;
                end
                S_RF_WAIT: begin
                    if (i_mem_done) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (i_resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (state == S_IDLE);
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_hit   = (state == S_RESP) && resp_hit;
    assign o_mem_valid  = (state == S_WB_REQ) || (state == S_RF_REQ);
    assign o_mem_wb     = (state == S_WB_REQ);
    assign o_tag_addr   = req_idx;
    assign o_hit_cnt    = hit_cnt;
    assign o_miss_cnt   = miss_cnt;

    always_comb begin
        o_mem_addr = '0;
        if (state == S_WB_REQ)
            o_mem_addr = {victim_tag, req_idx, {OFFSET_W{1'b0}}};
        else if (state == S_RF_REQ)
            o_mem_addr = {req_tag, req_idx, {OFFSET_W{1'b0}}};
    end

    // A store hit on a clean line only needs the dirty bit set; a miss writes once in UPDATE.
    always_comb begin
        o_tag_wen = 1'b0;
        o_tag_din = '0;
        if (state == S_LOOKUP && lookup_hit && req_wr && !entry_dirty) begin
            o_tag_wen              = 1'b1;
            o_tag_din[TAG_W+1:0]   = {1'b1, 1'b1, req_tag};
        end else if (state == S_UPDATE) begin
            o_tag_wen              = 1'b1;
            o_tag_din[TAG_W+1:0]   = {1'b1, req_wr, req_tag};
        end
    end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Directed bench for dcache_tag_ctrl with a behavioural 128-entry tag array.
module tb_dcache_tag_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_wr;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic        o_resp_hit;
    logic        o_tag_wen;
    logic [6:0]  o_tag_addr;
    logic [63:0] o_tag_din;
    logic [63:0] i_tag_dout;
    logic        o_mem_valid;
    logic        i_mem_ready;
    logic        o_mem_wb;
    logic [31:0] o_mem_addr;
    logic        i_mem_done;
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;

    int checks = 0;
    int fails  = 0;

    logic [63:0] tag_mem [128];

    dcache_tag_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_wr(i_req_wr),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_hit(o_resp_hit),
        .o_tag_wen(o_tag_wen), .o_tag_addr(o_tag_addr), .o_tag_din(o_tag_din),
        .i_tag_dout(i_tag_dout),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_wb(o_mem_wb),
        .o_mem_addr(o_mem_addr), .i_mem_done(i_mem_done),
        .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Tag array and memory share the reset domain, so the array starts cold.
    assign i_tag_dout = tag_mem[o_tag_addr];
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 128; i++) tag_mem[i] <= 64'd0;
        end else if (o_tag_wen) begin
            tag_mem[o_tag_addr] <= o_tag_din;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, o_req_ready, 1);
        chk({tag, "_resp_valid"}, o_resp_valid, 0);
        chk({tag, "_resp_hit"}, o_resp_hit, 0);
        chk({tag, "_mem_valid"}, o_mem_valid, 0);
        chk({tag, "_tag_wen"}, o_tag_wen, 0);
        chk({tag, "_mem_addr"}, o_mem_addr, 0);
        chk({tag, "_tag_din"}, o_tag_din, 0);
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr);
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        i_req_wr    = wr;
        step();
        i_req_valid = 1'b0;
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        i_req_wr     = 1'b0;
        i_resp_ready = 1'b0;
        i_mem_ready  = 1'b0;
        i_mem_done   = 1'b0;
        step();
        step();
        chk_idle_outputs("rst");
        chk("rst_hit_cnt", o_hit_cnt, 0);
        chk("rst_miss_cnt", o_miss_cnt, 0);
        i_rst_n = 1'b1;
        step();

        // 1: cold load miss, index 0x23, tag 0x2
        issue(32'h0000_1230, 1'b0);
        chk("t1_lookup_idx", o_tag_addr, 7'h23);
        chk("t1_lookup_wen", o_tag_wen, 0);
        chk("t1_lookup_rvalid", o_resp_valid, 0);
        step();
        chk("t1_rf_valid", o_mem_valid, 1);
        chk("t1_rf_wb", o_mem_wb, 0);
        chk("t1_rf_addr", o_mem_addr, 32'h0000_1230);
        chk("t1_miss_cnt", o_miss_cnt, 1);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        chk("t1_rfwait_valid", o_mem_valid, 0);
        step();
        chk("t1_rfwait_hold", o_tag_wen, 0);
        i_mem_done = 1'b1;
        step();
        i_mem_done = 1'b0;
        chk("t1_upd_wen", o_tag_wen, 1);
        chk("t1_upd_din", o_tag_din, 64'h0040_0002);
        chk("t1_upd_idx", o_tag_addr, 7'h23);
        step();
        chk("t1_resp_valid", o_resp_valid, 1);
        chk("t1_resp_hit", o_resp_hit, 0);
        chk("t1_resp_wen", o_tag_wen, 0);
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;
        chk_idle_outputs("t1_end");

        // 2: load hit, response in the second cycle after acceptance
        issue(32'h0000_1234, 1'b0);
        chk("t2_lookup_wen", o_tag_wen, 0);
        chk("t2_lookup_mem", o_mem_valid, 0);
        chk("t2_lookup_rvalid", o_resp_valid, 0);
        step();
        chk("t2_resp_valid", o_resp_valid, 1);
        chk("t2_resp_hit", o_resp_hit, 1);
        chk("t2_hit_cnt", o_hit_cnt, 1);
        chk("t2_miss_cnt", o_miss_cnt, 1);
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;

        // 3: store hit on clean line marks it dirty during lookup
        issue(32'h0000_1238, 1'b1);
        chk("t3_lookup_wen", o_tag_wen, 1);
        chk("t3_lookup_din", o_tag_din, 64'h0060_0002);
        chk("t3_lookup_mem", o_mem_valid, 0);
        step();
        chk("t3_resp_hit", o_resp_hit, 1);
        chk("t3_resp_wen", o_tag_wen, 0);
        chk("t3_entry", tag_mem[7'h23], 64'h0060_0002);
        chk("t3_hit_cnt", o_hit_cnt, 2);
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;

        // 4+5: conflicting load evicts the dirty line, with backpressure
        issue(32'h0008_1230, 1'b0);
        chk("t4_lookup_wen", o_tag_wen, 0);
        step();
        chk("t4_miss_cnt", o_miss_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            chk("t5_wb_valid", o_mem_valid, 1);
            chk("t5_wb_wb", o_mem_wb, 1);
            chk("t5_wb_addr", o_mem_addr, 32'h0000_1230);
            step();
        end
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        chk("t4_wbwait_valid", o_mem_valid, 0);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        chk("t4_wbwait_stay", o_mem_valid, 0);
        i_mem_done = 1'b1;
        step();
        i_mem_done = 1'b0;
        chk("t4_rf_valid", o_mem_valid, 1);
        chk("t4_rf_wb", o_mem_wb, 0);
        chk("t4_rf_addr", o_mem_addr, 32'h0008_1230);
        chk("t4_rf_wen", o_tag_wen, 0);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        i_mem_done = 1'b1;
        step();
        i_mem_done = 1'b0;
        chk("t4_upd_wen", o_tag_wen, 1);
        chk("t4_upd_din", o_tag_din, 64'h0040_0102);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("t5_resp_valid", o_resp_valid, 1);
            chk("t5_resp_hit", o_resp_hit, 0);
            step();
        end
        chk("t4_entry", tag_mem[7'h23], 64'h0040_0102);
        i_resp_ready = 1'b1;
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h0008_1234;
        i_req_wr     = 1'b0;
        step();
        i_resp_ready = 1'b0;
        chk("t5_no_same_cycle_accept", o_req_ready, 1);
        chk("t5_resp_dropped", o_resp_valid, 0);
        step();
        i_req_valid = 1'b0;
        chk("t5_accept_next", o_req_ready, 0);
        step();
        chk("t5_rehit", o_resp_hit, 1);
        chk("t5_hit_cnt", o_hit_cnt, 3);
        i_resp_ready = 1'b1;
        step();
        i_resp_ready = 1'b0;

        // 6: async reset during refill wait
        issue(32'h0004_1230, 1'b1);
        step();
        chk("t6_rf_addr", o_mem_addr, 32'h0004_1230);
        chk("t6_miss_cnt", o_miss_cnt, 3);
        i_mem_ready = 1'b1;
        step();
        i_mem_ready = 1'b0;
        #3;
        i_rst_n = 1'b0;
        #1;
        chk_idle_outputs("t6_rst");
        chk("t6_hit_cnt", o_hit_cnt, 0);
        chk("t6_miss_cnt0", o_miss_cnt, 0);
        chk("t6_tag_addr", o_tag_addr, 0);
        step();
        #2;
        i_rst_n = 1'b1;
        step();
        issue(32'h0008_1230, 1'b0);
        step();
        chk("t6_cold_rf_valid", o_mem_valid, 1);
        chk("t6_cold_rf_wb", o_mem_wb, 0);
        chk("t6_cold_rf_addr", o_mem_addr, 32'h0008_1230);
        chk("t6_cold_miss_cnt", o_miss_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
